// File: rtl/hex_display_scanner.sv
// Time-multiplexed 8-digit hex display driver with anti-ghost blanking,
// leading-zero suppression and a per-scan snapshot of the displayed word.
module hex_display_scanner #(
    parameter int unsigned SLOT_CYCLES  = 50000,
    parameter int unsigned BLANK_CYCLES = 500
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] data,
    input  logic        enable,
    input  logic        blankZeros,
    input  logic [7:0]  dpMask,
    output logic [7:0]  anodes,
    output logic [6:0]  segments,
    output logic        dp,
    output logic        scanDone
);

    localparam int unsigned CntW = (SLOT_CYCLES > 1) ? $clog2(SLOT_CYCLES) : 1;
    localparam logic [CntW-1:0] SlotLast = CntW'(SLOT_CYCLES - 1);
    localparam logic [CntW-1:0] BlankEnd = CntW'(BLANK_CYCLES);

    logic [CntW-1:0] slot_cnt_q, slot_cnt_d;
    logic [2:0]      digit_idx_q, digit_idx_d;
    logic [31:0]     snap_q, snap_d;
    logic [7:0]      anodes_q, anodes_d;
    logic [6:0]      segments_q, segments_d;
    logic            dp_q, dp_d;
    logic            scan_done_q, scan_done_d;

    logic [2:0] lead;
    logic [3:0] nibble;
    logic       slot_end;
    logic       lit;

    function automatic logic [6:0] hex_glyph(input logic [3:0] nib);
        logic [6:0] g;
        unique case (nib)
            4'h0: g = 7'b1000000;
            4'h1: g = 7'b1111001;
            4'h2: g = 7'b0100100;
            4'h3: g = 7'b0110000;
            4'h4: g = 7'b0011001;
            4'h5: g = 7'b0010010;
            4'h6: g = 7'b0000010;
            4'h7: g = 7'b1111000;
            4'h8: g = 7'b0000000;
            4'h9: g = 7'b0010000;
            4'hA: g = 7'b0001000;
            4'hB: g = 7'b0000011;
            4'hC: g = 7'b1000110;
            4'hD: g = 7'b0100001;
            4'hE: g = 7'b0000110;
            4'hF: g = 7'b0001110;
        endcase
        return g;
    endfunction

    assign slot_end = enable && (slot_cnt_q == SlotLast);

    always_comb begin
        slot_cnt_d  = slot_cnt_q;
        digit_idx_d = digit_idx_q;
        snap_d      = snap_q;
        scan_done_d = 1'b0;
        if (enable) begin
            slot_cnt_d = slot_end ? '0 : slot_cnt_q + 1'b1;
            if (slot_end) begin
                digit_idx_d = digit_idx_q + 3'd1;
                // Snapshot only at the 7->0 wrap so a scan never tears.
                if (digit_idx_q == 3'd7) begin
                    snap_d      = data;
                    scan_done_d = 1'b1;
                end
            end
        end
    end

    always_comb begin
        lead = 3'd0;
        for (int k = 1; k < 8; k++) begin
            if (snap_q[4*k +: 4] != 4'h0) lead = 3'(k);
        end
    end

    assign nibble = snap_q[{digit_idx_q, 2'b00} +: 4];

    always_comb begin
        lit = enable && (slot_cnt_q >= BlankEnd) && !(blankZeros && (digit_idx_q > lead));
        anodes_d   = 8'hFF;
        segments_d = 7'h7F;
        dp_d       = 1'b1;
        if (lit) begin
            anodes_d              = 8'hFF;
            anodes_d[digit_idx_q] = 1'b0;
            segments_d            = hex_glyph(nibble);
            dp_d                  = ~dpMask[digit_idx_q];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            slot_cnt_q  <= '0;
            digit_idx_q <= 3'd0;
            snap_q      <= 32'h0;
            anodes_q    <= 8'hFF;
            segments_q  <= 7'h7F;
            dp_q        <= 1'b1;
            scan_done_q <= 1'b0;
        end else begin
            slot_cnt_q  <= slot_cnt_d;
            digit_idx_q <= digit_idx_d;
            snap_q      <= snap_d;
            anodes_q    <= anodes_d;
            segments_q  <= segments_d;
            dp_q        <= dp_d;
            scan_done_q <= scan_done_d;
        end
    end

    assign anodes   = anodes_q;
    assign segments = segments_q;
    assign dp       = dp_q;
    assign scanDone = scan_done_q;

endmodule

// File: tb/tb_hex_display_scanner.sv
// Scoreboard bench for hex_display_scanner: a behavioural model queues the
// expected registered outputs per edge, compared on the following falling edge.
module tb_hex_display_scanner;

    localparam int unsigned Slot  = 8;
    localparam int unsigned Blank = 2;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [31:0] data = 32'h0;
    logic        enable = 1'b0;
    logic        blank_zeros = 1'b0;
    logic [7:0]  dp_mask = 8'h00;
    logic [7:0]  anodes;
    logic [6:0]  segments;
    logic        dp;
    logic        scan_done;

    hex_display_scanner #(
        .SLOT_CYCLES (Slot),
        .BLANK_CYCLES(Blank)
    ) u_dut (
        .clk       (clk),
        .rst       (rst),
        .data      (data),
        .enable    (enable),
        .blankZeros(blank_zeros),
        .dpMask    (dp_mask),
        .anodes    (anodes),
        .segments  (segments),
        .dp        (dp),
        .scanDone  (scan_done)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [7:0] an;
        logic [6:0] seg;
        logic       dp;
        logic       done;
    } exp_t;

    exp_t        sb[$];
    int          n_checks = 0;
    int          n_err = 0;
    int          edge_cnt = 0;
    int          m_slot = 0;
    int          m_digit = 0;
    logic [31:0] m_snap = 32'h0;
    logic [6:0]  glyph_tab[16] = '{
        7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
        7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
        7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
        7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110
    };

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", tag, act, exp, $time);
        end
    endtask

    function automatic int lead_of(input logic [31:0] w);
        int k = 7;
        while (k > 0 && w[4*k +: 4] == 4'h0) k--;
        return k;
    endfunction

    // One clock: predict outputs from pre-edge model state, advance model, then compare.
    task automatic step();
        exp_t e;
        logic lit;
        @(posedge clk);
        edge_cnt++;
        if (rst) begin
            e = '{an: 8'hFF, seg: 7'h7F, dp: 1'b1, done: 1'b0};
            m_slot  = 0;
            m_digit = 0;
            m_snap  = 32'h0;
        end else begin
            lit = enable && (m_slot >= Blank) &&
                  !(blank_zeros && (m_digit > lead_of(m_snap)));
            e.an   = lit ? ~(8'h01 << m_digit) : 8'hFF;
            e.seg  = lit ? glyph_tab[m_snap[4*m_digit +: 4]] : 7'h7F;
            e.dp   = !(lit && dp_mask[m_digit]);
            e.done = enable && (m_slot == Slot - 1) && (m_digit == 7);
            if (enable) begin
                if (m_slot == Slot - 1) begin
                    m_slot = 0;
                    if (m_digit == 7) begin
                        m_digit = 0;
                        m_snap  = data;
                    end else begin
                        m_digit++;
                    end
                end else begin
                    m_slot++;
                end
            end
        end
        sb.push_back(e);
        @(negedge clk);
        e = sb.pop_front();
        check_eq("anodes", 32'(anodes), 32'(e.an));
        check_eq("segments", 32'(segments), 32'(e.seg));
        check_eq("dp", 32'(dp), 32'(e.dp));
        check_eq("scanDone", 32'(scan_done), 32'(e.done));
    endtask

    task automatic steps(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic run_until_done();
        for (int i = 0; i < 100; i++) begin
            step();
            if (scan_done) break;
        end
        check_eq("done_seen", 32'(scan_done), 32'd1);
    endtask

    initial begin
        // Reset with stimulus for the first scenario already applied.
        data   = 32'h12345678;
        enable = 1'b1;
        #2 rst = 1'b1;
        #1;
        check_eq("rst_anodes", 32'(anodes), 32'hFF);
        check_eq("rst_segments", 32'(segments), 32'h7F);
        steps(3);
        rst      = 1'b0;
        edge_cnt = 0;

        // First scanDone lands 64 clocks after release.
        run_until_done();
        check_eq("first_done_clk", 32'(edge_cnt), 32'd64);
        steps(3);
        check_eq("dig0_anode", 32'(anodes), 32'hFE);
        check_eq("dig0_glyph8", 32'(segments), 32'b0000000);
        steps(56);
        check_eq("dig7_anode", 32'(anodes), 32'h7F);
        check_eq("dig7_glyph1", 32'(segments), 32'b1111001);

        // Leading-zero suppression, then an all-zero word.
        data = 32'h000000A0;
        run_until_done();
        blank_zeros = 1'b1;
        steps(64);
        data = 32'h0;
        run_until_done();
        steps(64);

        // Mid-scan data change must not tear the scan in progress.
        blank_zeros = 1'b0;
        data = 32'h11111111;
        run_until_done();
        steps(20);
        data = 32'h22222222;
        run_until_done();
        steps(64);

        // Freeze at digit 3, slot 5 for 20 clocks.
        for (int i = 0; i < 100 && !(m_digit == 3 && m_slot == 5); i++) step();
        check_eq("freeze_point", 32'(m_digit * 8 + m_slot), 32'd29);
        enable = 1'b0;
        steps(20);
        check_eq("frozen_anodes", 32'(anodes), 32'hFF);
        enable = 1'b1;
        steps(40);

        // Decimal point on digit 0, then an asynchronous mid-scan reset.
        dp_mask = 8'h01;
        steps(64);
        steps(13);
        rst = 1'b1;
        #1;
        check_eq("async_anodes", 32'(anodes), 32'hFF);
        check_eq("async_segments", 32'(segments), 32'h7F);
        check_eq("async_dp", 32'(dp), 32'd1);
        check_eq("async_done", 32'(scan_done), 32'd0);
        steps(3);
        rst      = 1'b0;
        edge_cnt = 0;
        run_until_done();
        check_eq("restart_done_clk", 32'(edge_cnt), 32'd64);
        steps(10);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
